// File: rtl/alu_addsub_shift_unit_pkg.sv
// Shared encodings for the ALU add/sub/shift datapath: path select, shift direction, aluc codes.
package alu_addsub_shift_unit_pkg;

  typedef enum logic {
    OP_ADDSUB = 1'b0,
    OP_SHIFT  = 1'b1
  } op_sel_e;

  typedef enum logic {
    SH_LEFT  = 1'b0,
    SH_RIGHT = 1'b1
  } sh_dir_e;

  typedef enum logic [2:0] {
    ALUC_AND  = 3'd0,
    ALUC_OR   = 3'd1,
    ALUC_ADD  = 3'd2,
    ALUC_SUB  = 3'd3,
    ALUC_ADD2 = 3'd4,
    ALUC_SLL  = 3'd5,
    ALUC_SRL  = 3'd6,
    ALUC_SRA  = 3'd7
  } aluc_e;

  function automatic logic aluc_is_shift(input aluc_e code);
    return (code == ALUC_SLL) || (code == ALUC_SRL) || (code == ALUC_SRA);
  endfunction

endpackage

// File: rtl/alu_addsub_shift_unit_barrel_shift32.sv
// Combinational 32-bit barrel shifter, five log stages (1,2,4,8,16); no latency, no flow control.
module barrel_shift32
  import alu_addsub_shift_unit_pkg::*;
(
  input  logic [31:0] d,
  input  logic [4:0]  sa,
  input  logic        right,
  input  logic        arith,
  output logic [31:0] sh
);

  logic [5:0][31:0] stg;
  logic             is_right;
  logic             fill;

  assign is_right = (sh_dir_e'(right) == SH_RIGHT);
  // Sign fill only applies to arithmetic right shifts.
  assign fill     = arith & is_right & d[31];
  assign stg[0]   = d;

  for (genvar i = 0; i < 5; i++) begin : g_stage
    localparam int K = 1 << i;
    assign stg[i+1] = !sa[i]   ? stg[i] :
                      is_right ? {{K{fill}}, stg[i][31:K]} :
                                 {stg[i][31-K:0], {K{1'b0}}};
  end

  assign sh = stg[5];

endmodule

// File: rtl/alu_addsub_shift_unit.sv
// Registered 32-bit add/sub + barrel-shift ALU datapath; latency 1, accepts every cycle, no backpressure.
// Defining ADDSUB_OVF_EN adds the registered signed-overflow output ovf.
module alu_addsub_shift_unit
  import alu_addsub_shift_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             in_valid,
  input  logic             op_shift,
  input  logic             sub,
  input  logic             right,
  input  logic             arith,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             out_valid
`ifdef ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   s;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] next_result;
  logic             next_carry;
  logic             is_shift;

  // Subtract as a + ~b + 1 so carry out is borrow-not.
  assign bx = b ^ {WIDTH{sub}};
  assign s  = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};

  barrel_shift32 u_shift (
    .d     (b),
    .sa    (a[4:0]),
    .right (right),
    .arith (arith),
    .sh    (sh)
  );

  assign is_shift    = (op_sel_e'(op_shift) == OP_SHIFT);
  assign next_result = is_shift ? sh : s[WIDTH-1:0];
  assign next_carry  = is_shift ? 1'b0 : s[WIDTH];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      result    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= next_result;
        zero   <= (next_result == '0);
        carry  <= next_carry;
      end
    end
  end

`ifdef ADDSUB_OVF_EN
  logic next_ovf;

  assign next_ovf = is_shift ? 1'b0
                             : ((a[WIDTH-1] ~^ bx[WIDTH-1]) & (s[WIDTH-1] ^ a[WIDTH-1]));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= next_ovf;
    end
  end
`endif

endmodule

// File: tb/tb_alu_addsub_shift_unit.sv
// Self-checking bench for alu_addsub_shift_unit: arithmetic reference model plus directed literal vectors.
module tb_alu_addsub_shift_unit;

  logic        clk = 1'b0;
  logic        clrn;
  logic        in_valid, op_shift, sub, right, arith;
  logic [31:0] a, b;
  logic [31:0] result;
  logic        zero, carry, out_valid;
`ifdef ADDSUB_OVF_EN
  logic        ovf;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  alu_addsub_shift_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .in_valid  (in_valid),
    .op_shift  (op_shift),
    .sub       (sub),
    .right     (right),
    .arith     (arith),
    .a         (a),
    .b         (b),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .out_valid (out_valid)
`ifdef ADDSUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: plain integer arithmetic on the captured operands.
  logic [31:0] m_res;
  logic        m_z, m_c, m_v, m_o;

  always @(posedge clk or negedge clrn) begin
    logic [31:0] r;
    logic        c, o;
    longint      ssum;
    if (!clrn) begin
      m_res <= '0; m_z <= 1'b0; m_c <= 1'b0; m_v <= 1'b0; m_o <= 1'b0;
    end else begin
      m_v <= in_valid;
      if (in_valid) begin
        if (op_shift) begin
          if (!right)     r = b << a[4:0];
          else if (arith) r = $unsigned($signed(b) >>> a[4:0]);
          else            r = b >> a[4:0];
          c = 1'b0;
          o = 1'b0;
        end else if (sub) begin
          r    = a - b;
          c    = (a >= b);
          ssum = longint'($signed(a)) - longint'($signed(b));
          o    = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
        end else begin
          r    = a + b;
          c    = ((64'(a) + 64'(b)) >> 32) != 0;
          ssum = longint'($signed(a)) + longint'($signed(b));
          o    = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
        end
        m_res <= r; m_z <= (r == 0); m_c <= c; m_o <= o;
      end
    end
  end

  always @(negedge clk) begin
    chk("model out_valid", {31'b0, out_valid}, {31'b0, m_v});
    chk("model result",    result,             m_res);
    chk("model zero",      {31'b0, zero},      {31'b0, m_z});
    chk("model carry",     {31'b0, carry},     {31'b0, m_c});
`ifdef ADDSUB_OVF_EN
    chk("model ovf",       {31'b0, ovf},       {31'b0, m_o});
`endif
  end

  task automatic drive(input logic sh, input logic sb, input logic rt, input logic ar,
                       input logic [31:0] va, input logic [31:0] vb);
    in_valid = 1'b1; op_shift = sh; sub = sb; right = rt; arith = ar; a = va; b = vb;
  endtask

  task automatic do_op(input string nm, input logic sh, input logic sb, input logic rt,
                       input logic ar, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] er, input logic ez, input logic ec, input logic eo);
    @(posedge clk); #1;
    drive(sh, sb, rt, ar, va, vb);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({nm, " result"}, result, er);
    chk({nm, " zero"},  {31'b0, zero},  {31'b0, ez});
    chk({nm, " carry"}, {31'b0, carry}, {31'b0, ec});
    chk({nm, " valid"}, {31'b0, out_valid}, 32'd1);
`ifdef ADDSUB_OVF_EN
    chk({nm, " ovf"},   {31'b0, ovf},   {31'b0, eo});
`else
    if (eo) begin end
`endif
  endtask

  initial begin
    clrn = 1'b0;
    in_valid = 1'b0; op_shift = 1'b0; sub = 1'b0; right = 1'b0; arith = 1'b0;
    a = '0; b = '0;
    #2;
    chk("reset result", result, 32'h0);
    chk("reset valid",  {31'b0, out_valid}, 32'd0);
    chk("reset zero",   {31'b0, zero}, 32'd0);
    @(posedge clk); #1;
    clrn = 1'b1;

    do_op("add ovf",  1'b0, 1'b0, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset while an op is in flight.
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h11, 32'h22);
    #2;
    clrn = 1'b0;
    #1;
    chk("midreset result", result, 32'h0);
    chk("midreset valid",  {31'b0, out_valid}, 32'd0);
    chk("midreset carry",  {31'b0, carry}, 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clrn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post-reset result", result, 32'h0);
    chk("post-reset valid",  {31'b0, out_valid}, 32'd0);

    do_op("sub eq",   1'b0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd5, 32'h0, 1'b1, 1'b1, 1'b0);
    do_op("sub wrap", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    do_op("add wrap", 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b1, 1'b0);
    do_op("sll 4",    1'b1, 1'b0, 1'b0, 1'b0, 32'd4, 32'h80000010, 32'h00000100, 1'b0, 1'b0, 1'b0);
    do_op("srl 4",    1'b1, 1'b0, 1'b1, 1'b0, 32'd4, 32'h80000010, 32'h08000001, 1'b0, 1'b0, 1'b0);
    do_op("sra 4",    1'b1, 1'b0, 1'b1, 1'b1, 32'd4, 32'h80000010, 32'hF8000001, 1'b0, 1'b0, 1'b0);
    do_op("sll a25",  1'b1, 1'b0, 1'b0, 1'b1, 32'h25, 32'h80000010, 32'h00000200, 1'b0, 1'b0, 1'b0);
    do_op("sa0 pass", 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFFFFE0, 32'h9234_5678, 32'h92345678, 1'b0, 1'b0, 1'b0);
    do_op("sra 31",   1'b1, 1'b0, 1'b1, 1'b1, 32'd31, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    do_op("srl 31",   1'b1, 1'b0, 1'b1, 1'b0, 32'd31, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 1'b0);
    do_op("sll 31 z", 1'b1, 1'b0, 1'b0, 1'b0, 32'd31, 32'h2, 32'h0, 1'b1, 1'b0, 1'b0);

    // Back-to-back ops with alternating paths; the model checks each one a cycle later.
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      drive(1'(i % 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom, $urandom);
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd100, 32'd23);
    @(posedge clk); #1;
    chk("b2b last result", result, 32'd123);
    chk("b2b last valid",  {31'b0, out_valid}, 32'd1);
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("idle valid",       {31'b0, out_valid}, 32'd0);
    chk("idle hold result", result, 32'd123);
    @(posedge clk); #1;
    chk("idle hold result2", result, 32'd123);

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
